// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: serializes valid/ready words into an external SISO chain
// and tags the bits that come out of the chain's O output with valid/last.
// The chain itself has no reset, so framing lives entirely in the tag
// pipelines here, which advance in lockstep with the chain via SER_CE.
module siso_shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             SER_I,
  output logic             SER_CE,
  input  logic             SISO_O,
  output logic             OUT_VALID,
  output logic             OUT_BIT,
  output logic             OUT_LAST,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [DEPTH-1:0]   vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0]   last_pipe_q, last_pipe_d;

  logic               accept;
  logic               word_end;
  logic [CW-1:0]      bit_idx;

  // Outputs decode straight from state; the chain only moves when we are busy
  always_comb begin
    word_end  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    IN_READY  = (state_q != SHIFT) || word_end;
    SER_CE    = (state_q != IDLE);
    BUSY      = (state_q != IDLE);
    bit_idx   = (MSB_FIRST != 0) ? (CNT_LAST - cnt_q) : cnt_q;
    SER_I     = (state_q == SHIFT) && shadow_q[bit_idx];
    OUT_VALID = vld_pipe_q[DEPTH-1];
    OUT_LAST  = last_pipe_q[DEPTH-1];
    OUT_BIT   = SISO_O;
    accept    = IN_VALID && IN_READY;
  end

  // Next-state: sequencing FSM plus tag pipelines that mirror the chain
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    shadow_d    = shadow_q;
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_d = IN_DATA;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (word_end) begin
          if (accept) begin
            // back-to-back word: no bubble between words
            shadow_d = IN_DATA;
            cnt_d    = '0;
          end else begin
            state_d = FLUSH;
            fcnt_d  = '0;
          end
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (accept) begin
          shadow_d = IN_DATA;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else if (fcnt_q == FCNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tags move only with the chain so they stay aligned with SISO_O
    if (SER_CE) begin
      vld_pipe_d  = DEPTH'({vld_pipe_q, (state_q == SHIFT)});
      last_pipe_d = DEPTH'({last_pipe_q, word_end});
    end

    // synchronous abort looks exactly like reset; chain contents are left
    // alone but the zeroed tags hide them
    if (CLR) begin
      state_d     = IDLE;
      cnt_d       = '0;
      fcnt_d      = '0;
      shadow_d    = '0;
      vld_pipe_d  = '0;
      last_pipe_d = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      shadow_q    <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      shadow_q    <= shadow_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: a word-level model predicts handshake, serial
// stream and output tags each cycle; directed tests pin it with literals.
module tb_siso_shift_ctrl;

  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid;
  logic [W-1:0] in_data;
  logic in_ready, ser_i, ser_ce, siso_o, out_valid, out_bit, out_last, busy;

  // second instance: LSB first, single-stage chain
  logic v2, clr2, r2, ser_i2, ce2, o2, ov2, ob2, ol2, busy2;
  logic [W-1:0] d2;

  // chains start with ones so stale content is visible if mis-tagged
  logic [D-1:0] chain  = '1;
  logic         chain2 = 1'b1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_dut (
    .CLK(clk), .RESETN(rst_n), .CLR(clr), .IN_VALID(in_valid),
    .IN_READY(in_ready), .IN_DATA(in_data), .SER_I(ser_i), .SER_CE(ser_ce),
    .SISO_O(siso_o), .OUT_VALID(out_valid), .OUT_BIT(out_bit),
    .OUT_LAST(out_last), .BUSY(busy));

  siso_shift_ctrl #(.WIDTH(W), .DEPTH(1), .MSB_FIRST(0)) u_dut2 (
    .CLK(clk), .RESETN(rst_n), .CLR(clr2), .IN_VALID(v2),
    .IN_READY(r2), .IN_DATA(d2), .SER_I(ser_i2), .SER_CE(ce2),
    .SISO_O(o2), .OUT_VALID(ov2), .OUT_BIT(ob2),
    .OUT_LAST(ol2), .BUSY(busy2));

  // SISO datapaths (no reset)
  always @(posedge clk) if (ser_ce) chain <= {chain[D-2:0], ser_i};
  always @(posedge clk) if (ce2) chain2 <= ser_i2;
  assign siso_o = chain[D-1];
  assign o2     = chain2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  // bits_left: data bits still to send of the current word
  // drain: trailing cycles still needed to push the last bits out of the chain
  int           bits_left = 0;
  int           drain     = 0;
  logic [W-1:0] m_word    = '0;
  logic [D-1:0] hv = '0, hb = '0, hl = '0;  // bit 0 = most recently sent

  logic m_busy, m_ready, m_seri;
  assign m_busy  = (bits_left > 0) || (drain > 0);
  assign m_ready = (bits_left <= 1);
  assign m_seri  = (bits_left > 0) ? m_word[bits_left-1] : 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      bits_left = 0; drain = 0; m_word = '0; hv = '0; hb = '0; hl = '0;
    end else begin
      if (m_busy) begin
        hv = {hv[D-2:0], (bits_left > 0)};
        hb = {hb[D-2:0], m_seri};
        hl = {hl[D-2:0], (bits_left == 1)};
      end
      if (in_valid && m_ready) begin
        m_word = in_data; bits_left = W; drain = 0;
      end else if (bits_left > 0) begin
        bits_left--;
        if (bits_left == 0) drain = D;
      end else if (drain > 0) begin
        drain--;
      end
    end
  end

  // ---------------- compare + capture ----------------
  logic cap_b[$];
  logic cap_l[$];
  int   cap_t[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("in_ready",  in_ready,  m_ready);
      chk("busy",      busy,      m_busy);
      chk("ser_ce",    ser_ce,    m_busy);
      chk("ser_i",     ser_i,     m_seri);
      chk("out_valid", out_valid, hv[D-1]);
      chk("out_last",  out_last,  hl[D-1]);
      chk("out_bit_passthru", out_bit, siso_o);
      if (hv[D-1]) chk("out_bit", out_bit, hb[D-1]);
      if (out_valid) begin
        cap_b.push_back(out_bit);
        cap_l.push_back(out_last);
        cap_t.push_back(cyc);
      end
    end
  end

  function automatic logic [15:0] pack_b(int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n && i < cap_b.size(); i++) v = {v[14:0], cap_b[i]};
    return v;
  endfunction

  function automatic logic [15:0] pack_l(int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n && i < cap_l.size(); i++) v = {v[14:0], cap_l[i]};
    return v;
  endfunction

  task automatic clear_cap();
    cap_b.delete(); cap_l.delete(); cap_t.delete();
  endtask

  // present a word from a negedge; returns at the negedge after acceptance
  task automatic send(input logic [W-1:0] w);
    int i;
    in_valid = 1'b1;
    in_data  = w;
    for (i = 0; i < 100; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (i == 100) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int rl, bc, fl;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    v2 = 1'b0; clr2 = 1'b0; d2 = '0;
    idle(2);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_ser_ce",    ser_ce,    1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ser_i",     ser_i,     1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: single word 0xA5
    clear_cap();
    send(8'hA5);
    rl = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) rl++;
      if (busy) bc++;
      @(negedge clk);
    end
    chk("t1_ready_low", rl, 7);
    chk("t1_busy_cycles", bc, 11);
    chk("t1_nbits", cap_b.size(), 8);
    chk("t1_data", pack_b(8), 16'h00A5);
    chk("t1_last", pack_l(8), 16'h0001);

    // 2: back-to-back 0x3C, 0xFF
    clear_cap();
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);               // accepted from IDLE
    in_data = 8'hFF;
    fl = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    @(negedge clk);               // second word accepted at word end
    in_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (busy && in_ready) fl++;
      @(negedge clk);
    end
    chk("t2_nbits", cap_b.size(), 16);
    chk("t2_data", pack_b(16), 16'h3CFF);
    chk("t2_last", pack_l(16), 16'h0101);
    if (cap_t.size() == 16) chk("t2_gap", cap_t[8] - cap_t[7] - 1, 0);
    chk("t2_ready_busy_cycles", fl, 4);

    // 3: 0x81, stall, 0x7E lands in FLUSH
    clear_cap();
    send(8'h81);
    idle(9);                      // SHIFT x8 then first FLUSH cycle
    send(8'h7E);                  // accepted in second FLUSH cycle
    idle(20);
    chk("t3_nbits", cap_b.size(), 16);
    chk("t3_data", pack_b(16), 16'h817E);
    chk("t3_last", pack_l(16), 16'h0101);
    if (cap_t.size() == 16) chk("t3_gap", cap_t[8] - cap_t[7] - 1, 2);

    // 4: async reset at bit 4 of 0xF0
    send(8'hF0);
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_in_ready",  in_ready,  1'b1);
    chk("t4_busy",      busy,      1'b0);
    chk("t4_ser_ce",    ser_ce,    1'b0);
    chk("t4_ser_i",     ser_i,     1'b0);
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_out_last",  out_last,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_cap();
    idle(10);
    chk("t4_no_valid", cap_b.size(), 0);
    send(8'h5A);
    idle(15);
    chk("t4_nbits", cap_b.size(), 8);
    chk("t4_data", pack_b(8), 16'h005A);

    // 6: CLR in SHIFT cycle 2
    clear_cap();
    send(8'hC3);
    idle(2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_busy",     busy,     1'b0);
    idle(15);
    chk("t6_no_valid", cap_b.size(), 0);

    // 5: LSB first, DEPTH=1, word 0x01
    v2 = 1'b1; d2 = 8'h01;
    @(negedge clk);
    v2 = 1'b0; d2 = 8'hFF;
    chk("t5_ser_i0", ser_i2, 1'b1);
    chk("t5_ov0",    ov2,    1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("t5_valid", ov2, (k <= 8));
      chk("t5_last",  ol2, (k == 8));
      if (k <= 8) chk("t5_bit", ob2, (k == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
